// File: rtl/voice_allocator.sv
// Voice allocator: assigns note-on/off commands to voices and mixes voice samples into one frame sample.
// Optional build macro VOICE_STEAL_EN: when no voice is free, steal the oldest busy voice.
module voice_allocator #(
  parameter int NUM_VOICES = 10,
  parameter int MIDI_W     = 7,
  parameter int VEL_W      = 8,
  parameter int SAMPLE_W   = 16,
  parameter int MIX_SHIFT  = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [MIDI_W+VEL_W:0]          i_data,
  output logic [NUM_VOICES-1:0]          o_cmd,
  output logic [NUM_VOICES-1:0]          o_trig,
  output logic [NUM_VOICES*MIDI_W-1:0]   o_midi,
  output logic [NUM_VOICES*VEL_W-1:0]    o_vel,
  output logic                           o_overflow,
  input  logic [NUM_VOICES-1:0]          i_state,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] i_sample,
  output logic [SAMPLE_W-1:0]            o_sample,
  output logic                           o_sample_valid
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] APPLY = 1'b1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (SAMPLE_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [0:0]            state;
  logic                  cmd_on;
  logic [MIDI_W-1:0]     cmd_note;
  logic [VEL_W-1:0]      cmd_vel;
  logic [NUM_VOICES-1:0] note_match;
  logic                  hit, free, alloc_en, drop;
  logic [IDX_W-1:0]      hit_idx, free_idx, alloc_idx;

  assign o_ready = (state == IDLE);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    note_match = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    free       = 1'b0;
    free_idx   = '0;
    // Scanning downward leaves the lowest matching index in place.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      note_match[v] = o_cmd[v] && (o_midi[v*MIDI_W +: MIDI_W] == cmd_note);
      if (note_match[v]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(v);
      end
      if (!o_cmd[v]) begin
        free     = 1'b1;
        free_idx = IDX_W'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [4:0]       age [NUM_VOICES];
  logic [IDX_W-1:0] steal_idx;
  logic [4:0]       steal_age;

  always_comb begin
    steal_idx = '0;
    steal_age = age[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age[v] > steal_age) begin
        steal_idx = IDX_W'(v);
        steal_age = age[v];
      end
    end
  end

  assign alloc_en  = (state == APPLY) && cmd_on && !hit;
  assign alloc_idx = free ? free_idx : steal_idx;

  // NOTE: the age array is small control state that steal decisions read, so it is reset like any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
    end else if (alloc_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (IDX_W'(v) == alloc_idx)      age[v] <= '0;
        else if (o_cmd[v] && age[v] != '1) age[v] <= age[v] + 5'd1;
      end
    end
  end
`else
  assign alloc_en  = (state == APPLY) && cmd_on && !hit && free;
  assign alloc_idx = free_idx;
`endif

  assign drop = (state == APPLY) && cmd_on && !hit && !free;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd_on     <= 1'b0;
      cmd_note   <= '0;
      cmd_vel    <= '0;
      o_cmd      <= '0;
      o_trig     <= '0;
      o_midi     <= '1;
      o_vel      <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_trig     <= '0;
      o_overflow <= drop;
      if (state == IDLE) begin
        if (i_valid) begin
          {cmd_on, cmd_note, cmd_vel} <= i_data;
          state <= APPLY;
        end
      end else begin
        state <= IDLE;
        if (cmd_on && hit) begin
          o_vel[hit_idx*VEL_W +: VEL_W] <= cmd_vel;
          o_trig[hit_idx]               <= 1'b1;
        end
        if (alloc_en) begin
          o_cmd[alloc_idx]                    <= 1'b1;
          o_midi[alloc_idx*MIDI_W +: MIDI_W]  <= cmd_note;
          o_vel[alloc_idx*VEL_W +: VEL_W]     <= cmd_vel;
          o_trig[alloc_idx]                   <= 1'b1;
        end
        if (!cmd_on) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (note_match[v]) begin
              o_cmd[v]                    <= 1'b0;
              o_midi[v*MIDI_W +: MIDI_W]  <= '1;
            end
          end
        end
      end
    end
  end

  // Frame mixer: one voice per cycle, free-running scan.
  logic [IDX_W-1:0]           idx;
  logic signed [ACC_W-1:0]    acc, term, total, shifted;
  logic signed [SAMPLE_W-1:0] cur;

  always_comb begin
    cur     = i_sample[idx*SAMPLE_W +: SAMPLE_W];
    term    = i_state[idx] ? {{(ACC_W-SAMPLE_W){cur[SAMPLE_W-1]}}, cur} : '0;
    total   = acc + term;
    shifted = total >>> MIX_SHIFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx            <= '0;
      acc            <= '0;
      o_sample       <= '0;
      o_sample_valid <= 1'b0;
    end else if (idx == IDX_W'(NUM_VOICES - 1)) begin
      idx            <= '0;
      acc            <= '0;
      o_sample_valid <= 1'b1;
      if (shifted > SAT_MAX)      o_sample <= SAT_MAX[SAMPLE_W-1:0];
      else if (shifted < SAT_MIN) o_sample <= SAT_MIN[SAMPLE_W-1:0];
      else                        o_sample <= shifted[SAMPLE_W-1:0];
    end else begin
      idx            <= idx + 1'b1;
      acc            <= total;
      o_sample_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random traffic against a voice/mixer model.
module tb_voice_allocator;
  localparam int N  = 10;
  localparam int MW = 7;
  localparam int VW = 8;
  localparam int SW = 16;
  localparam int SH = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [MW+VW:0]    i_data;
  logic [N-1:0]      o_cmd, o_trig, i_state;
  logic [N*MW-1:0]   o_midi;
  logic [N*VW-1:0]   o_vel;
  logic              o_overflow;
  logic [N*SW-1:0]   i_sample;
  logic [SW-1:0]     o_sample;
  logic              o_sample_valid;

  voice_allocator #(.NUM_VOICES(N), .MIDI_W(MW), .VEL_W(VW), .SAMPLE_W(SW), .MIX_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_cmd(o_cmd), .o_trig(o_trig), .o_midi(o_midi), .o_vel(o_vel), .o_overflow(o_overflow),
    .i_state(i_state), .i_sample(i_sample), .o_sample(o_sample), .o_sample_valid(o_sample_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-voice ownership table, pending command, frame accumulator.
  bit          m_on   [N];
  logic [6:0]  m_note [N];
  logic [7:0]  m_vel  [N];
  int          m_age  [N];
  bit          m_busy;
  logic [15:0] m_pend;
  logic [N-1:0] e_trig;
  bit          e_ovf;
  int          m_slot, m_sum;
  logic [SW-1:0] e_sample;
  bit          e_valid;

  function automatic void model_reset();
    for (int v = 0; v < N; v++) begin
      m_on[v] = 0; m_note[v] = 7'h7f; m_vel[v] = 0; m_age[v] = 0;
    end
    m_busy = 0; m_pend = 0; e_trig = 0; e_ovf = 0;
    m_slot = 0; m_sum = 0; e_sample = 0; e_valid = 0;
  endfunction

  function automatic void model_alloc(input int v, input logic [6:0] n, input logic [7:0] vel);
    for (int u = 0; u < N; u++)
      if (u != v && m_on[u] && m_age[u] < 31) m_age[u]++;
    m_on[v] = 1; m_note[v] = n; m_vel[v] = vel; m_age[v] = 0; e_trig[v] = 1'b1;
  endfunction

  function automatic void model_apply(input logic [15:0] c);
    logic [6:0] n;
    logic [7:0] vel;
    int target;
    n = c[14:8];
    vel = c[7:0];
    if (c[15]) begin
      target = -1;
      for (int v = N - 1; v >= 0; v--) if (m_on[v] && m_note[v] == n) target = v;
      if (target >= 0) begin
        m_vel[target] = vel; e_trig[target] = 1'b1;
        return;
      end
      for (int v = N - 1; v >= 0; v--) if (!m_on[v]) target = v;
      if (target >= 0) begin
        model_alloc(target, n, vel);
        return;
      end
      e_ovf = 1;
`ifdef VOICE_STEAL_EN
      target = 0;
      for (int v = 1; v < N; v++) if (m_age[v] > m_age[target]) target = v;
      model_alloc(target, n, vel);
`endif
    end else begin
      for (int v = 0; v < N; v++)
        if (m_on[v] && m_note[v] == n) begin
          m_on[v] = 0; m_note[v] = 7'h7f;
        end
    end
  endfunction

  function automatic void model_edge();
    int t;
    e_trig = 0; e_ovf = 0;
    if (m_busy) begin
      model_apply(m_pend); m_busy = 0;
    end else if (i_valid) begin
      m_pend = i_data; m_busy = 1;
    end
    if (i_state[m_slot]) begin
      t = $signed(i_sample[m_slot*SW +: SW]);
      m_sum += t;
    end
    if (m_slot == N - 1) begin
      t = m_sum >>> SH;
      if (t > 32767) t = 32767;
      if (t < -32768) t = -32768;
      e_sample = t[SW-1:0]; e_valid = 1; m_sum = 0; m_slot = 0;
    end else begin
      e_valid = 0; m_slot++;
    end
  endfunction

  task automatic compare_all();
    logic [N-1:0]    ec;
    logic [N*MW-1:0] em;
    logic [N*VW-1:0] ev;
    for (int v = 0; v < N; v++) begin
      ec[v] = m_on[v]; em[v*MW +: MW] = m_note[v]; ev[v*VW +: VW] = m_vel[v];
    end
    check("ready", o_ready, !m_busy);
    check("cmd", o_cmd, ec);
    check("trig", o_trig, e_trig);
    check("midi", o_midi, em);
    check("vel", o_vel, ev);
    check("overflow", o_overflow, e_ovf);
    check("sample_valid", o_sample_valid, e_valid);
    check("sample", o_sample, e_sample);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [15:0] d);
    i_valid = 1'b1; i_data = d;
    tick();
    i_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_cmd", o_cmd, '0);
    check("rst_trig", o_trig, '0);
    check("rst_midi", o_midi, {N*MW{1'b1}});
    check("rst_vel", o_vel, '0);
    check("rst_ovf", o_overflow, 1'b0);
    check("rst_sample", o_sample, '0);
    check("rst_valid", o_sample_valid, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_samples(input logic [SW-1:0] s);
    for (int v = 0; v < N; v++) i_sample[v*SW +: SW] = s;
  endtask

  task automatic mix_frame(input string tag, input logic [SW-1:0] exp);
    int guard = 0;
    tick();
    while (m_slot != 0 && guard < 2 * N) begin
      tick(); guard++;
    end
    for (int k = 0; k < N; k++) tick();
    check({tag, "_valid"}, o_sample_valid, 1'b1);
    check(tag, o_sample, exp);
  endtask

  initial begin
    int lat;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_state = '0; i_sample = '0;
    model_reset();
    do_reset();

    // Single note-on lands in voice 0.
    send(16'hBC40);
    check("first_cmd", o_cmd, 10'h001);
    check("first_note", o_midi[6:0], 7'd60);
    check("first_vel", o_vel[7:0], 8'd64);

    // Allocate 60/62/64, release 62, then 67 refills voice 1.
    do_reset();
    send(16'hBC40); send(16'hBE40); send(16'hC040);
    check("three_cmd", o_cmd, 10'h007);
    send(16'h3E00);
    check("off_cmd", o_cmd, 10'h005);
    check("off_note", o_midi[13:7], 7'h7f);
    send(16'hC350);
    check("refill_note", o_midi[13:7], 7'd67);

    // Retrigger of a held note keeps a single voice.
    do_reset();
    send(16'hBC40); send(16'hBC64);
    check("retrig_cmd", o_cmd, 10'h001);
    check("retrig_vel", o_vel[7:0], 8'd100);

    // Eleven note-ons on ten voices.
    do_reset();
    for (int k = 0; k < 11; k++) send({1'b1, 7'(50 + k), 8'd90});
    check("full_cmd", o_cmd, 10'h3ff);
`ifdef VOICE_STEAL_EN
    check("steal_v0", o_midi[6:0], 7'd60);
`else
    check("drop_v0", o_midi[6:0], 7'd50);
`endif

    // Mixer saturation and plain scaling.
    i_state = '1;
    set_samples(16'h7fff);
    mix_frame("mix_sat", 16'h7fff);
    set_samples(16'h1000);
    mix_frame("mix_1000", 16'h1400);
    set_samples(16'h8000);
    mix_frame("mix_neg", 16'h8000);

    // Reset mid-frame at scan index 5 with voices busy.
    lat = 0;
    while (m_slot != 5 && lat < 2 * N) begin
      tick(); lat++;
    end
    check("midframe_idx", m_slot, 5);
    do_reset();
    lat = 0;
    do begin
      tick(); lat++;
    end while (!o_sample_valid && lat < 3 * N);
    check("valid_latency", lat, N);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = {1'($urandom_range(0, 9) < 7), 7'(50 + $urandom_range(0, 13)), 8'($urandom)};
      i_state = N'($urandom);
      for (int v = 0; v < N; v++) i_sample[v*SW +: SW] = SW'($urandom);
      if (c % 1000 == 999) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Parametrised voice manager between the MIDI command decoder and the NUM_VOICES phase_bank/quarter_sine pairs.
- Allocates exactly one free voice per note-on and releases the matching voice on note-off.
- Retriggers a voice when a note-on arrives for a note it already holds.
- Mixes the active voices' samples into one saturated frame sample every NUM_VOICES cycles.

Parameters:
- NUM_VOICES, 10, number of voices (2..32)
- MIDI_W, 7, note-number width
- VEL_W, 8, velocity width
- SAMPLE_W, 16, signed two's-complement sample width
- MIX_SHIFT, 3, arithmetic right shift applied to the frame sum before saturation

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_valid  in  1  command valid
- o_ready  out  1  command accept; transfer occurs when i_valid && o_ready
- i_data  in  1+MIDI_W+VEL_W  [MSB]=1 note-on / 0 note-off, then note, then velocity (16 bits at defaults)
- o_cmd  out  NUM_VOICES  per-voice gate (1 = voice owned)
- o_trig  out  NUM_VOICES  one-cycle pulse per voice: phase restart
- o_midi  out  NUM_VOICES*MIDI_W  per-voice note, voice v at [v*MIDI_W +: MIDI_W]
- o_vel  out  NUM_VOICES*VEL_W  per-voice velocity, packed as o_midi
- o_overflow  out  1  one-cycle pulse: note-on dropped or voice stolen
- i_state  in  NUM_VOICES  per-voice active flag from phase_bank
- i_sample  in  NUM_VOICES*SAMPLE_W  per-voice sample, packed as o_midi
- o_sample  out  SAMPLE_W  mixed frame sample
- o_sample_valid  out  1  one-cycle pulse when o_sample updates

Behaviour:
- Reset (async): o_cmd=0, o_trig=0, o_midi all ones (7'h7f per voice), o_vel=0, o_overflow=0, o_sample=0, o_sample_valid=0, scan index=0, accumulator=0, ages=0, FSM=IDLE.
- Reset mid-frame discards the partial sum; no valid pulse is produced.
- Command FSM IDLE/APPLY:
  - o_ready=1 only in IDLE.
  - An accepted command is latched and moves the FSM to APPLY.
  - APPLY updates the voice registers at its clock edge and returns to IDLE.
  - Maximum throughput is one command per 2 cycles.
  - Voice outputs change 2 edges after acceptance.
- Note-on, held-note hit (a voice v with o_cmd[v]=1 and o_midi[v]==note): lowest such v gets o_vel[v]=vel and o_trig[v]=1; no new voice is allocated.
- Note-on, otherwise: the lowest-index v with o_cmd[v]=0 gets o_cmd[v]=1, o_midi[v]=note, o_vel[v]=vel, o_trig[v]=1, age[v]=0. Exactly one voice is allocated.
- Note-on with all voices busy and no hit: command dropped, o_overflow pulses 1 cycle (macro off).
- Note-off: every v with o_cmd[v]=1 and o_midi[v]==note gets o_cmd[v]=0 and o_midi[v]=all ones. No match: no effect.
- Ages: on each allocating note-on, every other busy voice's age increments, saturating at 2^5-1.
- o_trig and o_overflow are cleared the cycle after assertion.
- Mixer:
  - Scan index idx runs 0..NUM_VOICES-1 and wraps, one voice per cycle, independent of the FSM.
  - Each cycle, if i_state[idx], the sign-extended i_sample[idx] is added to an accumulator of width SAMPLE_W+clog2(NUM_VOICES).
  - At idx==NUM_VOICES-1 the total (acc + current term) is shifted by >>> MIX_SHIFT, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], and registered into o_sample. o_sample_valid pulses and the accumulator clears in the same edge.
  - First valid pulse: NUM_VOICES edges after reset release.
  - No active voices: o_sample=0 and the valid pulse still occurs.

Optional Feature:
- Macro VOICE_STEAL_EN.
- Defined: a note-on with no free voice and no hit steals the busy voice with maximum age (ties: lowest index). That voice gets the new note/vel, o_trig=1, age=0, and o_overflow pulses.
- Undefined: the command is dropped with o_overflow pulse; age counters are not synthesised.

Test Plan:
- Reset, then note-on 16'hBC40 (note 60, vel 64) -> only voice 0: o_cmd=0x001, o_midi[0]=60, o_vel[0]=64, o_trig[0] 1-cycle pulse, o_ready low exactly 1 cycle.
- Note-on notes 60,62,64, then note-off 62 (16'h3E00) -> o_cmd 0x007 then 0x005, o_midi[1]=7'h7f; next note-on 67 lands in voice 1.
- Note-on 60 twice (vel 64, then vel 100) -> single voice, o_cmd=0x001, o_vel[0]=100, two o_trig[0] pulses.
- 11 note-ons (notes 50..60), macro off -> o_cmd=0x3FF, 11th dropped, one o_overflow pulse. Macro on -> voice 0 (oldest) holds note 60.
- i_state=all ones, every i_sample=16'h7FFF, MIX_SHIFT=3 -> o_sample=16'h7FFF (saturated). Every i_sample=16'h1000 -> o_sample=16'h1400. o_sample_valid every 10 cycles.
- Assert rst mid-frame (idx=5) with voices busy -> all outputs at reset values immediately; next o_sample_valid 10 edges after release.
